// File: rtl/can_pkg.sv
// Shared types and constants for the CAN CRC-15 sequencer.
package can_pkg;

  localparam logic [14:0] CRC15_POLY = 15'h4599;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HEADER    = 2'd1,
    DATA      = 2'd2,
    CRC_FIELD = 2'd3
  } state_t;

  // Bit positions counted from SOF (SOF = index 0).
  localparam logic [6:0] STD_RTR     = 7'd12;
  localparam logic [6:0] IDE_IDX     = 7'd13;
  localparam logic [6:0] STD_DLC_LO  = 7'd15;
  localparam logic [6:0] STD_HDR_END = 7'd18;
  localparam logic [6:0] EXT_RTR     = 7'd32;
  localparam logic [6:0] EXT_DLC_LO  = 7'd35;
  localparam logic [6:0] EXT_HDR_END = 7'd38;

  // One serial CRC-15 step: feedback is the incoming bit xor the register MSB.
  function automatic logic [14:0] crc15_step(input logic [14:0] crc, input logic b);
    logic fb;
    fb = b ^ crc[14];
    return {crc[13:0], 1'b0} ^ (fb ? CRC15_POLY : 15'h0000);
  endfunction

endpackage

// File: rtl/crc15_serial.sv
// Serial CRC-15 LFSR. Clear and enable in the same cycle restarts the
// register from zero and accumulates the current bit (SOF handling).
module crc15_serial
  import can_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_en,
  input  logic        i_clr,
  input  logic        i_bit,
  output logic [14:0] o_crc
);

  logic [14:0] r_crc;
  logic [14:0] w_base;

  assign w_base = i_clr ? 15'h0000 : r_crc;

  // LFSR register: accumulate on enable, otherwise clear or hold.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_crc <= '0;
    end else if (i_en) begin
      r_crc <= crc15_step(w_base, i_bit);
    end else if (i_clr) begin
      r_crc <= '0;
    end
  end

  assign o_crc = r_crc;

endmodule

// File: rtl/crc_sequencer.sv
// Sequences CAN CRC-15 over one destuffed frame: tracks the bit position from
// SOF, decodes IDE/RTR/DLC, gates accumulation up to the end of the data field,
// then shifts the CRC out (TX) or captures and compares it (RX).
// Handshake: i_bit_valid is a one-cycle strobe per destuffed bit; i_bit,
// i_frame_start and i_tx_mode are only meaningful while it is high. There is no
// back-pressure: every strobe is consumed on the edge where it is seen.
module crc_sequencer
  import can_pkg::*;
#(
  parameter bit EXT_EN    = 1'b1,
  parameter int MAX_BYTES = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bit_valid,
  input  logic        i_bit,
  input  logic        i_frame_start,
  input  logic        i_tx_mode,
  input  logic        i_abort,
  output logic        o_busy,
  output logic        o_crc_phase,
  output logic        o_tx_crc_bit,
  output logic [14:0] o_crc_value,
  output logic        o_done,
  output logic        o_crc_err,
  output logic [1:0]  o_dbg_state
);

  localparam logic [3:0] MAX_B = 4'(MAX_BYTES);

  state_t      r_state, w_state;
  logic [6:0]  r_bit_cnt, w_bit_cnt;
  logic [3:0]  r_crc_cnt, w_crc_cnt;
  logic [14:0] r_rx_crc, w_rx_crc;
  logic        r_tx_mode, w_tx_mode;
  logic        r_ide, w_ide;
  logic        r_rtr, w_rtr;
  logic [2:0]  r_dlc, w_dlc;          // first three DLC bits; the fourth arrives live
  logic [6:0]  r_data_left, w_data_left;
  logic        r_done, w_done;
  logic        r_crc_err, w_crc_err;

  logic        w_crc_en, w_crc_clr;
  logic [14:0] w_crc;
  logic        w_sof;
  logic        w_in_dlc, w_hdr_end;
  logic [3:0]  w_dlc_full, w_bytes;
  logic [6:0]  w_data_bits;
  logic [3:0]  w_tx_idx;

  crc15_serial u_crc (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .i_en  (w_crc_en),
    .i_clr (w_crc_clr),
    .i_bit (i_bit),
    .o_crc (w_crc)
  );

  assign w_sof       = i_bit_valid & i_frame_start & ~i_abort;
  assign w_in_dlc    = r_ide ? (r_bit_cnt >= EXT_DLC_LO && r_bit_cnt <= EXT_HDR_END)
                             : (r_bit_cnt >= STD_DLC_LO && r_bit_cnt <= STD_HDR_END);
  assign w_hdr_end   = r_ide ? (r_bit_cnt == EXT_HDR_END) : (r_bit_cnt == STD_HDR_END);
  assign w_dlc_full  = {r_dlc, i_bit};
  assign w_bytes     = (w_dlc_full > MAX_B) ? MAX_B : w_dlc_full;
  assign w_data_bits = r_rtr ? 7'd0 : {w_bytes, 3'b000};

  // State and frame-tracking registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_bit_cnt   <= '0;
      r_crc_cnt   <= '0;
      r_rx_crc    <= '0;
      r_tx_mode   <= 1'b0;
      r_ide       <= 1'b0;
      r_rtr       <= 1'b0;
      r_dlc       <= '0;
      r_data_left <= '0;
      r_done      <= 1'b0;
      r_crc_err   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_bit_cnt   <= w_bit_cnt;
      r_crc_cnt   <= w_crc_cnt;
      r_rx_crc    <= w_rx_crc;
      r_tx_mode   <= w_tx_mode;
      r_ide       <= w_ide;
      r_rtr       <= w_rtr;
      r_dlc       <= w_dlc;
      r_data_left <= w_data_left;
      r_done      <= w_done;
      r_crc_err   <= w_crc_err;
    end
  end

  // Next-state, field decode and CRC gating; abort beats a new SOF.
  always_comb begin
    w_state     = r_state;
    w_bit_cnt   = r_bit_cnt;
    w_crc_cnt   = r_crc_cnt;
    w_rx_crc    = r_rx_crc;
    w_tx_mode   = r_tx_mode;
    w_ide       = r_ide;
    w_rtr       = r_rtr;
    w_dlc       = r_dlc;
    w_data_left = r_data_left;
    w_done      = 1'b0;
    w_crc_err   = 1'b0;
    w_crc_en    = 1'b0;
    w_crc_clr   = 1'b0;
    if (i_abort) begin
      w_state = IDLE;
    end else if (w_sof) begin
      w_state   = HEADER;
      w_bit_cnt = 7'd1;
      w_crc_cnt = '0;
      w_rx_crc  = '0;
      w_tx_mode = i_tx_mode;
      w_ide     = 1'b0;
      w_rtr     = 1'b0;
      w_dlc     = '0;
      w_crc_en  = 1'b1;
      w_crc_clr = 1'b1;
    end else if (i_bit_valid) begin
      case (r_state)
        HEADER: begin
          w_crc_en  = 1'b1;
          w_bit_cnt = r_bit_cnt + 7'd1;
          // Index 12 is RTR for standard frames and SRR for extended ones;
          // the extended RTR at index 32 overwrites it.
          if (r_bit_cnt == STD_RTR || (r_ide && r_bit_cnt == EXT_RTR)) w_rtr = i_bit;
          if (r_bit_cnt == IDE_IDX) begin
            w_ide = i_bit;
            if (i_bit && !EXT_EN) begin
              w_state   = IDLE;
              w_done    = 1'b1;
              w_crc_err = 1'b1;
            end
          end
          if (w_in_dlc) w_dlc = {r_dlc[1:0], i_bit};
          if (w_hdr_end) begin
            w_data_left = w_data_bits;
            w_crc_cnt   = '0;
            w_state     = (w_data_bits == 7'd0) ? CRC_FIELD : DATA;
          end
        end
        DATA: begin
          w_crc_en    = 1'b1;
          w_bit_cnt   = r_bit_cnt + 7'd1;
          w_data_left = r_data_left - 7'd1;
          if (r_data_left == 7'd1) w_state = CRC_FIELD;
        end
        CRC_FIELD: begin
          w_crc_cnt = r_crc_cnt + 4'd1;
          if (!r_tx_mode) w_rx_crc = {r_rx_crc[13:0], i_bit};
          if (r_crc_cnt == 4'd14) begin
            w_state   = IDLE;
            w_done    = 1'b1;
            w_crc_err = !r_tx_mode && ({r_rx_crc[13:0], i_bit} != w_crc);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_tx_idx     = 4'd14 - r_crc_cnt;
  assign o_busy       = (r_state != IDLE);
  assign o_crc_phase  = (r_state == CRC_FIELD);
  assign o_tx_crc_bit = o_crc_phase & r_tx_mode & w_crc[w_tx_idx];
  assign o_crc_value  = w_crc;
  assign o_done       = r_done;
  assign o_crc_err    = r_crc_err;
  assign o_dbg_state  = r_state;

endmodule
